// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared opcode/state enums, constants and opcode helpers for the divider controller
package div_pkg;

    typedef enum logic [2:0] {
        OP_DIV   = 3'b000,
        OP_REM   = 3'b001,
        OP_RSV2  = 3'b010,
        OP_RSV3  = 3'b011,
        OP_DIVW  = 3'b100,
        OP_DIVUW = 3'b101,
        OP_REMW  = 3'b110,
        OP_REMUW = 3'b111
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } div_state_e;

    localparam logic [63:0] INT64_MIN = 64'h8000_0000_0000_0000;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    function automatic logic op_is_word(input logic [2:0] op);
        return op[2];
    endfunction

    // DIVW/REMW are the sign-extending word ops; DIVUW/REMUW zero-extend
    function automatic logic op_is_signed_word(input logic [2:0] op);
        return op[2] && !op[0];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] ? op[1] : op[0];
    endfunction

    function automatic logic op_is_reserved(input logic [2:0] op);
        return op[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/div_fmt_64b.sv
// rtl/div_fmt_64b.sv - operand extension, special-case detection and result formatting
module div_fmt_64b
    import div_pkg::*;
(
    input  div_op_e     op,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] ext_a,
    output logic [63:0] ext_b,
    output logic        special,
    output logic [63:0] special_data,
    output logic        special_err,
    input  logic [63:0] core_quotient,
    input  logic [63:0] core_remainder,
    output logic [63:0] result_data
);

    logic        is_word;
    logic        is_signed_word;
    logic        is_rem;
    logic        is_rsv;
    logic        div_zero;
    logic        overflow;
    logic [63:0] a_sext;
    logic [63:0] sel;

    assign is_word        = op_is_word(op);
    assign is_signed_word = op_is_signed_word(op);
    assign is_rem         = op_is_rem(op);
    assign is_rsv         = op_is_reserved(op);
    assign a_sext         = {{32{a[31]}}, a[31:0]};

    always_comb begin
        ext_a = a;
        ext_b = b;
        if (is_word) begin
            ext_a = is_signed_word ? a_sext : {32'b0, a[31:0]};
            ext_b = is_signed_word ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
        end
    end

    assign div_zero = (ext_b == 64'd0);
    assign overflow = ((op == OP_DIV)  && (a == INT64_MIN) && (b == '1)) ||
                      ((op == OP_DIVW) && (a[31:0] == INT32_MIN) && (b[31:0] == '1));

    assign special     = is_rsv || div_zero || overflow;
    assign special_err = is_rsv;

    always_comb begin
        special_data = '0;
        if (is_rsv) begin
            special_data = '0;
        end else if (div_zero) begin
            special_data = is_rem ? (is_word ? a_sext : a) : '1;
        end else if (overflow) begin
            special_data = is_word ? {32'hFFFF_FFFF, INT32_MIN} : INT64_MIN;
        end
    end

    // Word results are always sign-extended from bit 31, unsigned ones included
    assign sel         = is_rem ? core_remainder : core_quotient;
    assign result_data = is_word ? {{32{sel[31]}}, sel[31:0]} : sel;

endmodule

// File: rtl/div_ctl_64b.sv
// rtl/div_ctl_64b.sv - request/response controller wrapping an external iterative 64-bit divider
module div_ctl_64b
    import div_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  op_i,
    input  logic [4:0]  tag_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    output logic        div_init_o,
    output logic [63:0] div_dividend_o,
    output logic [63:0] div_divisor_o,
    input  logic        div_done_i,
    input  logic [63:0] div_quotient_i,
    input  logic [63:0] div_remainder_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [4:0]  out_tag_o,
    output logic [63:0] out_data_o,
    output logic        out_err_o
);

    div_state_e  state_q, state_d;
    div_op_e     op_q, op_sel;
    logic [4:0]  tag_q;
    logic [63:0] dividend_q, divisor_q, data_q;
    logic        err_q;
    logic        wait_first_q;
    logic        accept, capture;

    logic [63:0] fmt_ext_a, fmt_ext_b, fmt_special_data, fmt_result;
    logic        fmt_special, fmt_special_err;

    // In IDLE the formatter looks at the incoming request; afterwards at the held one
    assign op_sel  = (state_q == ST_IDLE) ? div_op_e'(op_i) : op_q;
    assign accept  = in_valid_i && (state_q == ST_IDLE);
    assign capture = (state_q == ST_WAIT) && !wait_first_q && div_done_i;

    div_fmt_64b u_fmt (
        .op             (op_sel),
        .a              (a_i),
        .b              (b_i),
        .ext_a          (fmt_ext_a),
        .ext_b          (fmt_ext_b),
        .special        (fmt_special),
        .special_data   (fmt_special_data),
        .special_err    (fmt_special_err),
        .core_quotient  (div_quotient_i),
        .core_remainder (div_remainder_i),
        .result_data    (fmt_result)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (in_valid_i) state_d = fmt_special ? ST_RESP : ST_LAUNCH;
            ST_LAUNCH: if (div_done_i) state_d = ST_WAIT;
            ST_WAIT:   if (capture)    state_d = ST_RESP;
            ST_RESP:   if (out_ready_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = 1'b0;
        div_init_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            ST_IDLE:   in_ready_o  = 1'b1;
            ST_LAUNCH: div_init_o  = 1'b1;
            ST_RESP:   out_valid_o = 1'b1;
            default:   ;
        endcase
    end

    // The core may keep done high for a cycle after init, so done is not trusted on the first WAIT cycle
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q         <= OP_DIV;
            tag_q        <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            wait_first_q <= 1'b0;
        end else begin
            wait_first_q <= (state_q == ST_LAUNCH) && div_done_i;
            if (accept) begin
                op_q       <= op_sel;
                tag_q      <= tag_i;
                dividend_q <= fmt_ext_a;
                divisor_q  <= fmt_ext_b;
                err_q      <= fmt_special_err;
                if (fmt_special) data_q <= fmt_special_data;
            end
            if (capture) begin
                data_q <= fmt_result;
                err_q  <= 1'b0;
            end
        end
    end

    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign out_tag_o      = tag_q;
    assign out_data_o     = data_q;
    assign out_err_o      = err_q;

endmodule

// File: tb/tb_div_ctl_64b.sv
// tb/tb_div_ctl_64b.sv - self-checking bench for div_ctl_64b with a behavioural divider core
module tb_div_ctl_64b;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [2:0]  op_i = '0;
    logic [4:0]  tag_i = '0;
    logic [63:0] a_i = '0;
    logic [63:0] b_i = '0;
    logic        div_init_o;
    logic [63:0] div_dividend_o;
    logic [63:0] div_divisor_o;
    logic        div_done_i;
    logic [63:0] div_quotient_i;
    logic [63:0] div_remainder_i;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [4:0]  out_tag_o;
    logic [63:0] out_data_o;
    logic        out_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    div_ctl_64b dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .op_i            (op_i),
        .tag_i           (tag_i),
        .a_i             (a_i),
        .b_i             (b_i),
        .div_init_o      (div_init_o),
        .div_dividend_o  (div_dividend_o),
        .div_divisor_o   (div_divisor_o),
        .div_done_i      (div_done_i),
        .div_quotient_i  (div_quotient_i),
        .div_remainder_i (div_remainder_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_tag_o       (out_tag_o),
        .out_data_o      (out_data_o),
        .out_err_o       (out_err_o)
    );

    // Behavioural signed 64-bit iterative core: idle -> done high; busy for core_lat+1 cycles
    int          core_lat = 3;
    logic        core_stall = 1'b0;
    logic        core_busy;
    int          core_cnt;
    logic [63:0] core_a, core_b;

    function automatic logic [63:0] core_q(input logic [63:0] a, input logic [63:0] b);
        longint x, y;
        x = a; y = b;
        if (y == 0) return '1;
        if (y == -1) return -x;
        return x / y;
    endfunction

    function automatic logic [63:0] core_r(input logic [63:0] a, input logic [63:0] b);
        longint x, y;
        x = a; y = b;
        if (y == 0) return a;
        if (y == -1) return '0;
        return x % y;
    endfunction

    assign div_done_i = !core_busy && !core_stall;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_busy       <= 1'b0;
            core_cnt        <= 0;
            core_a          <= '0;
            core_b          <= '0;
            div_quotient_i  <= '0;
            div_remainder_i <= '0;
        end else if (!core_busy) begin
            if (div_init_o && div_done_i) begin
                core_busy <= 1'b1;
                core_cnt  <= core_lat;
                core_a    <= div_dividend_o;
                core_b    <= div_divisor_o;
            end
        end else if (core_cnt == 0) begin
            core_busy       <= 1'b0;
            div_quotient_i  <= core_q(core_a, core_b);
            div_remainder_i <= core_r(core_a, core_b);
        end else begin
            core_cnt <= core_cnt - 1;
        end
    end

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference: RISC-V style division results computed directly from the opcode rules
    function automatic void ref_model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                      output logic [63:0] data, output logic err, output logic special);
        longint      sa, sb;
        int          wa, wb;
        int unsigned ua, ub;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        data = '0; err = 1'b0; special = 1'b0;
        case (op)
            3'b000: if (sb == 0) begin data = '1; special = 1'b1; end
                    else if (a == 64'h8000_0000_0000_0000 && sb == -1) begin data = a; special = 1'b1; end
                    else data = sa / sb;
            3'b001: if (sb == 0) begin data = a; special = 1'b1; end
                    else if (sb == -1) data = '0;
                    else data = sa % sb;
            3'b100: if (wb == 0) begin data = '1; special = 1'b1; end
                    else if (ua == 32'h8000_0000 && wb == -1) begin data = sx32(32'h8000_0000); special = 1'b1; end
                    else data = sx32(wa / wb);
            3'b101: if (ub == 0) begin data = '1; special = 1'b1; end
                    else data = sx32(ua / ub);
            3'b110: if (wb == 0) begin data = sx32(wa); special = 1'b1; end
                    else if (wb == -1) data = '0;
                    else data = sx32(wa % wb);
            3'b111: if (ub == 0) begin data = sx32(ua); special = 1'b1; end
                    else data = sx32(ua % ub);
            default: begin data = '0; err = 1'b1; special = 1'b1; end
        endcase
    endfunction

    function automatic logic [63:0] ext_ref(input logic [2:0] op, input logic [63:0] v);
        if (op == 3'b100 || op == 3'b110) return sx32(v[31:0]);
        if (op == 3'b101 || op == 3'b111) return {32'b0, v[31:0]};
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_req(input logic [2:0] op, input logic [4:0] tag, input logic [63:0] a, input logic [63:0] b,
                           input int hold, output logic [63:0] data, output logic err, output logic [4:0] otag,
                           output int lat, output int inits, output logic [63:0] sa, output logic [63:0] sb,
                           output logic [63:0] dd_at_resp, output bit hold_ok, output bit timed_out);
        @(negedge clk);
        in_valid_i = 1'b1; op_i = op; tag_i = tag; a_i = a; b_i = b;
        @(posedge clk);
        #1;
        in_valid_i = 1'b0; op_i = 3'($urandom); tag_i = 5'($urandom);
        a_i = {$urandom, $urandom}; b_i = {$urandom, $urandom};
        lat = 0; inits = 0; sa = '0; sb = '0; timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            lat++;
            if (div_init_o) begin
                inits++;
                sa = div_dividend_o;
                sb = div_divisor_o;
            end
            if (out_valid_o) begin
                timed_out = 1'b0;
                break;
            end
        end
        data = out_data_o; err = out_err_o; otag = out_tag_o; dd_at_resp = div_dividend_o;
        hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!out_valid_o || in_ready_o || out_data_o !== data || out_err_o !== err || out_tag_o !== otag)
                hold_ok = 1'b0;
        end
        out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        out_ready_i = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  tag;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic        err;
        logic        sp;
        logic [63:0] ea;
        logic [63:0] eb;
        int          hold;
    } vec_t;

    vec_t vt[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] data, sa, sb, dd, ed;
        logic        err, eerr, esp;
        logic [4:0]  otag;
        int          lat, inits, hold;
        bit          hold_ok, to;
        logic [2:0]  rop;
        logic [63:0] ra, rb;
        logic [4:0]  rtag;

        vt[0]  = '{3'b000, 5'h0A, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 10};
        vt[1]  = '{3'b111, 5'h11, 64'hFFFF_FFFF_0000_0007, 64'd3, 64'd1, 1'b0, 1'b0, 64'd7, 64'd3, 0};
        vt[2]  = '{3'b000, 5'h02, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'd0, 64'd0, 0};
        vt[3]  = '{3'b001, 5'h03, 64'd5, 64'd0, 64'd5, 1'b0, 1'b1, 64'd0, 64'd0, 2};
        vt[4]  = '{3'b100, 5'h04, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b1, 64'd0, 64'd0, 0};
        vt[5]  = '{3'b000, 5'h05, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 64'd0, 64'd0, 0};
        vt[6]  = '{3'b010, 5'h06, 64'd123, 64'd7, 64'd0, 1'b1, 1'b1, 64'd0, 64'd0, 1};
        vt[7]  = '{3'b011, 5'h07, 64'd9, 64'd0, 64'd0, 1'b1, 1'b1, 64'd0, 64'd0, 0};
        vt[8]  = '{3'b101, 5'h08, 64'hABCD_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 0};
        vt[9]  = '{3'b110, 5'h09, 64'h1234_5678_FFFF_FFF9, 64'hDEAD_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0};
        vt[10] = '{3'b111, 5'h1F, 64'h0000_0001_8000_0001, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b1, 64'd0, 64'd0, 0};
        vt[11] = '{3'b100, 5'h15, 64'h7777_0000_0000_0064, 64'h0000_0001_0000_0007, 64'd14, 1'b0, 1'b0, 64'd100, 64'd7, 0};
        vt[12] = '{3'b001, 5'h16, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0};

        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_init", div_init_o, 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_tag", out_tag_o, 0);
        chk("rst_err", out_err_o, 0);
        chk("rst_dividend", div_dividend_o, 0);
        rst_n = 1'b1;

        core_lat = 3;
        foreach (vt[i]) begin
            run_req(vt[i].op, vt[i].tag, vt[i].a, vt[i].b, vt[i].hold, data, err, otag, lat, inits, sa, sb, dd, hold_ok, to);
            chk($sformatf("vec%0d_timeout", i), to, 0);
            chk($sformatf("vec%0d_data", i), data, vt[i].exp);
            chk($sformatf("vec%0d_err", i), err, vt[i].err);
            chk($sformatf("vec%0d_tag", i), otag, vt[i].tag);
            chk($sformatf("vec%0d_hold", i), hold_ok, 1);
            chk($sformatf("vec%0d_next_ready", i), in_ready_o, 1);
            if (vt[i].sp) begin
                chk($sformatf("vec%0d_special_lat", i), lat, 1);
                chk($sformatf("vec%0d_no_init", i), inits, 0);
            end else begin
                chk($sformatf("vec%0d_lat_min", i), lat >= 3, 1);
                chk($sformatf("vec%0d_init_pulses", i), inits, 1);
                chk($sformatf("vec%0d_core_a", i), sa, vt[i].ea);
                chk($sformatf("vec%0d_core_b", i), sb, vt[i].eb);
                chk($sformatf("vec%0d_dividend_held", i), dd, vt[i].ea);
            end
        end

        // Core busy when launched: init must stay up until done returns
        core_stall = 1'b1;
        fork
            begin
                repeat (6) @(negedge clk);
                core_stall = 1'b0;
            end
        join_none
        run_req(3'b000, 5'h12, 64'd100, 64'd10, 0, data, err, otag, lat, inits, sa, sb, dd, hold_ok, to);
        chk("stall_timeout", to, 0);
        chk("stall_init_held", inits > 1, 1);
        chk("stall_data", data, 64'd10);

        // Reset during WAIT discards the request
        core_lat = 20;
        @(negedge clk);
        in_valid_i = 1'b1; op_i = 3'b000; tag_i = 5'h1A; a_i = 64'd100; b_i = 64'd10;
        @(posedge clk);
        #1 in_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_in_wait", in_ready_o | div_init_o | out_valid_o, 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready_o, 1);
        chk("mid_rst_out_valid", out_valid_o, 0);
        chk("mid_rst_data", out_data_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (30) begin
                @(negedge clk);
                if (out_valid_o) seen++;
            end
            chk("post_rst_no_resp", seen, 0);
        end
        core_lat = 2;
        run_req(3'b000, 5'h1B, 64'd100, 64'd10, 0, data, err, otag, lat, inits, sa, sb, dd, hold_ok, to);
        chk("post_rst_timeout", to, 0);
        chk("post_rst_data", data, 64'd10);
        chk("post_rst_tag", otag, 5'h1B);

        // Randomised requests against the reference model
        for (int n = 0; n < 60; n++) begin
            rop  = 3'($urandom);
            rtag = 5'($urandom);
            ra   = {$urandom, $urandom};
            case ($urandom_range(0, 6))
                0: rb = 64'd0;
                1: rb = 64'hFFFF_FFFF_FFFF_FFFF;
                2: rb = {$urandom, 32'd0};
                3: rb = {$urandom, 32'hFFFF_FFFF};
                4: rb = 64'($urandom_range(1, 20)) * (($urandom & 1) ? 64'd1 : 64'hFFFF_FFFF_FFFF_FFFF);
                default: rb = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0: ra = 64'h8000_0000_0000_0000;
                1: ra = {$urandom, 32'h8000_0000};
                default: ;
            endcase
            core_lat = $urandom_range(0, 5);
            hold     = $urandom_range(0, 3);
            ref_model(rop, ra, rb, ed, eerr, esp);
            run_req(rop, rtag, ra, rb, hold, data, err, otag, lat, inits, sa, sb, dd, hold_ok, to);
            chk($sformatf("rnd%0d_op%0d_timeout", n, rop), to, 0);
            chk($sformatf("rnd%0d_op%0d_data", n, rop), data, ed);
            chk($sformatf("rnd%0d_op%0d_err", n, rop), err, eerr);
            chk($sformatf("rnd%0d_op%0d_tag", n, rop), otag, rtag);
            chk($sformatf("rnd%0d_op%0d_hold", n, rop), hold_ok, 1);
            chk($sformatf("rnd%0d_op%0d_inits", n, rop), inits, esp ? 0 : 1);
            if (!esp) begin
                chk($sformatf("rnd%0d_op%0d_core_a", n, rop), sa, ext_ref(rop, ra));
                chk($sformatf("rnd%0d_op%0d_core_b", n, rop), sb, ext_ref(rop, rb));
            end else begin
                chk($sformatf("rnd%0d_op%0d_special_lat", n, rop), lat, 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
